// File: rtl/risc15_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc15_pkg
//  Description : Shared constants and types for the RISC15 memory responder.
//                Word/address widths, responder state encoding, op encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc15_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    // Wide enough to hold WAIT_STATES+1 for WAIT_STATES up to 15
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage : risc15_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : 2**ADDR_W x DATA_W word array, one synchronous write port and
//                one registered synchronous read port. Contents are never
//                cleared; only the read register is reset.
//  Ports       : clk, reset (sync, active-high)
//                we/waddr/wdata   - write port
//                re/raddr/rdata   - read port, rdata updates only when re=1
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between read strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : mem_array
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-side responder for RISC15. Accepts level-held
//                read/write requests, serves them from a word array after
//                WAIT_STATES wait cycles and pulses mem_ready for one cycle.
//                A side load port preloads words while the responder is idle.
//  Ports       : clk, reset (sync, active-high)
//                mem_addr/mem_wdata/mem_read/mem_write - request inputs
//                mem_rdata (registered), mem_ready (1-cycle pulse)
//                ld_en/ld_addr/ld_data - preload port, honoured in IDLE only
//                ld_busy - responder not idle; req_err - sticky collision flag
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W      = risc15_pkg::ADDR_W,
    parameter int DATA_W      = risc15_pkg::DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_busy,
    output logic              req_err
);

    import risc15_pkg::*;

    // WAIT lasts WAIT_STATES+1 cycles; the counter is preloaded with that
    // span and RESP is entered on the edge that sees it at 1.
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WAIT_STATES + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    op_t                r_op;
    logic               r_err;

    logic               w_req;
    logic               w_cap;
    logic               w_err_set;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_re;
    logic [ADDR_W-1:0]  w_raddr;

    assign w_req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_RD;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cap) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_op    <= mem_write ? OP_WR : OP_RD;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next state plus the array port mux (load path vs committed request)
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        w_err_set   = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_addr;
        w_wdata     = r_wdata;
        w_re        = 1'b0;
        w_raddr     = r_addr;

        case (r_state)
            IDLE: begin
                if (ld_en) begin
                    // Load wins; any pending request is taken on a later edge
                    w_we    = 1'b1;
                    w_waddr = ld_addr;
                    w_wdata = ld_data;
                end else if (w_req) begin
                    w_cap     = 1'b1;
                    w_err_set = mem_read & mem_write;
                    if (WAIT_STATES == 0) begin
                        // Acceptance edge is also the commit edge, so the
                        // live request inputs feed the array directly.
                        w_state_nxt = RESP;
                        w_cnt_nxt   = '0;
                        if (mem_write) begin
                            w_we    = 1'b1;
                            w_waddr = mem_addr;
                            w_wdata = mem_wdata;
                        end else begin
                            w_re    = 1'b1;
                            w_raddr = mem_addr;
                        end
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = '0;
                    if (r_op == OP_WR) begin
                        w_we = 1'b1;
                    end else begin
                        w_re = 1'b1;
                    end
                end
            end
            RESP: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                // Wait for the requester to drop its level-held request
                if (!w_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk    (clk),
        .reset  (reset),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  (w_wdata),
        .re     (w_re),
        .raddr  (w_raddr),
        .rdata  (mem_rdata)
    );

    assign mem_ready = (r_state == RESP);
    assign ld_busy   = (r_state != IDLE);
    assign req_err   = r_err;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench. Two responders (WAIT_STATES=2 and 0)
//                share one input stream; a transaction-level model predicts
//                each one's outputs every cycle. Directed sequences add
//                literal expectations, then a randomized phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        ld_en = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    // Index 0: WAIT_STATES=2, index 1: WAIT_STATES=0
    logic [15:0] d_rdata [2];
    logic        d_ready [2];
    logic        d_busy  [2];
    logic        d_err   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_STATES(2)) dut_w2 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(d_rdata[0]),
        .mem_ready(d_ready[0]), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_busy(d_busy[0]), .req_err(d_err[0])
    );

    data_mem_responder #(.ADDR_W(6), .DATA_W(16), .WAIT_STATES(0)) dut_w0 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(d_rdata[1]),
        .mem_ready(d_ready[1]), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_busy(d_busy[1]), .req_err(d_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A request accepted at edge k commits at edge k (W=0) or k+W+1 (W>0);
    // mem_ready is high in the cycle after the commit edge; the responder is
    // busy from acceptance until it samples the request low at an edge at
    // least two edges after the commit.
    logic [15:0] m_mem   [2][64];
    bit          m_busy  [2];
    longint      m_ce    [2];
    bit          m_wr    [2];
    logic [5:0]  m_addr  [2];
    logic [15:0] m_wdat  [2];
    logic [15:0] m_rdata [2];
    bit          m_err   [2];
    bit          m_rdy   [2];
    longint      k = 0;
    bit          m_valid = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int w;
            w = (i == 0) ? 2 : 0;
            m_rdy[i] = 1'b0;
            if (reset) begin
                m_busy[i]  = 1'b0;
                m_rdata[i] = '0;
                m_err[i]   = 1'b0;
            end else begin
                if (!m_busy[i]) begin
                    if (ld_en) begin
                        m_mem[i][ld_addr] = ld_data;
                    end else if (mem_read || mem_write) begin
                        m_wr[i]   = mem_write;
                        m_addr[i] = mem_addr;
                        m_wdat[i] = mem_wdata;
                        if (mem_read && mem_write) m_err[i] = 1'b1;
                        m_ce[i]   = k + ((w == 0) ? 0 : w + 1);
                        m_busy[i] = 1'b1;
                    end
                end else if (k >= m_ce[i] + 2 && !mem_read && !mem_write) begin
                    m_busy[i] = 1'b0;
                end
                if (m_busy[i] && k == m_ce[i]) begin
                    if (m_wr[i]) m_mem[i][m_addr[i]] = m_wdat[i];
                    else         m_rdata[i] = m_mem[i][m_addr[i]];
                    m_rdy[i] = 1'b1;
                end
            end
        end
        if (reset) m_valid = 1'b1;
        k++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_ready[%0d]", i), {31'd0, d_ready[i]}, {31'd0, m_rdy[i]});
                chk($sformatf("model_rdata[%0d]", i), {16'd0, d_rdata[i]}, {16'd0, m_rdata[i]});
                chk($sformatf("model_busy[%0d]", i),  {31'd0, d_busy[i]},  {31'd0, m_busy[i]});
                chk($sformatf("model_err[%0d]", i),   {31'd0, d_err[i]},   {31'd0, m_err[i]});
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [15:0] pre [64];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ld_en     = 1'b0;
        for (int j = 0; j < n; j++) step();
    endtask

    // Steps until the selected responder pulses ready; n = steps taken
    task automatic wait_ready(input int idx, output int n);
        n = 0;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (d_ready[idx]) begin
                n = j;
                break;
            end
        end
        if (n == 0) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int extra;

        // Reset state
        step();
        step();
        chk("rst_ready", {31'd0, d_ready[0]}, 32'd0);
        chk("rst_rdata", {16'd0, d_rdata[0]}, 32'd0);
        chk("rst_busy",  {31'd0, d_busy[0]},  32'd0);
        chk("rst_err",   {31'd0, d_err[0]},   32'd0);
        reset = 1'b0;
        step();

        // Preload every word
        for (int a = 0; a < 64; a++) begin
            ld_en   = 1'b1;
            ld_addr = 6'(a);
            ld_data = 16'($urandom);
            pre[a]  = ld_data;
            step();
        end
        ld_addr = 6'h05; ld_data = 16'hBEEF; pre[5] = 16'hBEEF; step();
        ld_addr = 6'h02; ld_data = 16'h5555; pre[2] = 16'h5555; step();
        ld_en = 1'b0;
        step();

        // Preload and read, WAIT_STATES=2: ready 4 cycles after request rises
        mem_addr = 6'h05;
        mem_read = 1'b1;
        wait_ready(0, n);
        chk("rd_latency", 32'(n), 32'd4);
        chk("rd_beef", {16'd0, d_rdata[0]}, 32'h0000BEEF);
        extra = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (d_ready[0]) extra++;
        end
        chk("no_second_pulse", 32'(extra), 32'd0);
        idle(2);

        // Write then read; read data untouched by the write
        mem_addr = 6'h3F; mem_wdata = 16'h1234; mem_write = 1'b1;
        wait_ready(0, n);
        chk("wr_keeps_rdata", {16'd0, d_rdata[0]}, 32'h0000BEEF);
        idle(2);
        mem_read = 1'b1;
        wait_ready(0, n);
        chk("rd_after_wr", {16'd0, d_rdata[0]}, 32'h00001234);
        idle(2);

        // Load and read in the same idle cycle: load first, read returns it
        ld_en = 1'b1; ld_addr = 6'h20; ld_data = 16'hCAFE;
        mem_addr = 6'h20; mem_read = 1'b1;
        step();
        ld_en = 1'b0;
        wait_ready(0, n);
        chk("collide_rd", {16'd0, d_rdata[0]}, 32'h0000CAFE);
        idle(2);

        // Load during WAIT is ignored
        mem_addr = 6'h21; mem_read = 1'b1;
        step();
        ld_en = 1'b1; ld_addr = 6'h21; ld_data = 16'h9999;
        step();
        chk("busy_in_wait", {31'd0, d_busy[0]}, 32'd1);
        ld_en = 1'b0;
        wait_ready(0, n);
        chk("ld_ignored", {16'd0, d_rdata[0]}, {16'd0, pre[6'h21]});
        idle(2);

        // Read+write collision: treated as write, sticky error
        mem_addr = 6'h10; mem_wdata = 16'h00FF; mem_read = 1'b1; mem_write = 1'b1;
        wait_ready(0, n);
        idle(3);
        chk("err_sticky", {31'd0, d_err[0]}, 32'd1);
        mem_addr = 6'h10; mem_read = 1'b1;
        wait_ready(0, n);
        chk("err_wrote", {16'd0, d_rdata[0]}, 32'h000000FF);
        idle(2);

        // Reset during WAIT of a write: aborted, old data survives
        mem_addr = 6'h02; mem_wdata = 16'hAAAA; mem_write = 1'b1;
        step();
        step();
        chk("abort_not_ready", {31'd0, d_ready[0]}, 32'd0);
        reset = 1'b1; mem_write = 1'b0;
        step();
        chk("abort_ready", {31'd0, d_ready[0]}, 32'd0);
        chk("abort_rdata", {16'd0, d_rdata[0]}, 32'd0);
        chk("abort_busy",  {31'd0, d_busy[0]},  32'd0);
        chk("abort_err",   {31'd0, d_err[0]},   32'd0);
        reset = 1'b0;
        step();
        mem_addr = 6'h02; mem_read = 1'b1;
        wait_ready(0, n);
        chk("abort_old_data", {16'd0, d_rdata[0]}, 32'h00005555);
        idle(2);

        // WAIT_STATES=0: ready right after acceptance, back-to-back reads
        mem_addr = 6'h05; mem_read = 1'b1;
        step();
        chk("w0_ready", {31'd0, d_ready[1]}, 32'd1);
        chk("w0_rdata", {16'd0, d_rdata[1]}, 32'h0000BEEF);
        step();
        chk("w0_single", {31'd0, d_ready[1]}, 32'd0);
        mem_read = 1'b0;
        step();
        mem_addr = 6'h3F; mem_read = 1'b1;
        step();
        chk("w0_b2b_ready", {31'd0, d_ready[1]}, 32'd1);
        chk("w0_b2b_rdata", {16'd0, d_rdata[1]}, 32'h00001234);
        idle(3);

        // Randomized phase, checked by the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            ld_en = ($urandom_range(0, 5) == 0);
            ld_addr = 6'($urandom);
            ld_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                mem_read  = ($urandom_range(0, 1) == 0);
                mem_write = ($urandom_range(0, 3) == 0);
                mem_addr  = 6'($urandom);
                mem_wdata = 16'($urandom);
            end
            step();
        end
        reset = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire
